// File: rtl/uart_tx_port_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register map, STATUS bit layout and serializer states.
package uart_tx_port_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_BAUD   = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam int ST_BUSY  = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_EMPTY = 2;
   localparam int ST_OVF   = 3;
   localparam int ST_CNT   = 4;
   localparam int ST_CNT_W = 4;

   localparam int FRAME_BITS = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } tx_state_t;

endpackage

// File: rtl/uart_tx_port_byte_fifo.sv
// Byte-wide synchronous FIFO; pushes while full are dropped,
// pops while empty are ignored, head is read from registered storage.
module byte_fifo
   import uart_tx_port_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [7:0]               din,
   input  logic                     pop,
   output logic [7:0]               head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_port.sv
// Bus-attached 8N1 transmitter: register decode, config,
// bit timer and serializer FSM draining a byte FIFO onto tx.
module uart_tx_port
   import uart_tx_port_pkg::*;
#(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd433
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        cs,
   input  logic        wr_rd,
   input  logic [31:0] data_bus_write,
   output logic [31:0] data_bus_read,
   output logic        tx
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 1);

   logic [1:0]    sel;
   logic          bus_wr;
   logic          bus_rd;
   logic [15:0]   divisor;
   logic [15:0]   period_div;
   logic [15:0]   bit_tmr;
   logic          enable;
   logic          overflow;
   tx_state_t     state;
   logic [7:0]    shift;
   logic [2:0]    bit_cnt;
   logic          bit_end;
   logic          busy;
   logic [31:0]   status;

   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_head;
   logic [CW-1:0] fifo_count;

   logic          unused_bits;

   assign sel    = addr[3:2];
   assign bus_wr = cs && wr_rd;
   assign bus_rd = cs && !wr_rd;

   assign unused_bits = ^{addr[31:4], addr[1:0],
                          data_bus_write[31:16]};

   assign fifo_push = bus_wr && (sel == REG_DATA);
   assign bit_end   = (bit_tmr == period_div);
   assign busy      = (state != S_IDLE) || !fifo_empty;

   // A pop happens only where the FSM loads a new frame.
   assign fifo_pop = enable && !fifo_empty &&
                     ((state == S_IDLE) ||
                      ((state == S_STOP) && bit_end));

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (data_bus_write[7:0]),
      .pop   (fifo_pop),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         divisor  <= DIV_RESET;
         enable   <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (bus_wr) begin
            unique case (1'b1)
               sel == REG_DATA:   ;
               sel == REG_STATUS: overflow <= 1'b0;
               sel == REG_BAUD:   divisor <= data_bus_write[15:0];
               sel == REG_CTRL:   enable <= data_bus_write[0];
            endcase
         end
         if (fifo_push && fifo_full) begin
            overflow <= 1'b1;
         end
      end
   end

   always_comb begin
      status                   = '0;
      status[ST_BUSY]          = busy;
      status[ST_FULL]          = fifo_full;
      status[ST_EMPTY]         = fifo_empty;
      status[ST_OVF]           = overflow;
      status[ST_CNT+:ST_CNT_W] = ST_CNT_W'(fifo_count);
   end

   always_comb begin
      data_bus_read = '0;
      if (bus_rd) begin
         unique case (1'b1)
            sel == REG_DATA:   data_bus_read = '0;
            sel == REG_STATUS: data_bus_read = status;
            sel == REG_BAUD:   data_bus_read = {16'h0, divisor};
            sel == REG_CTRL:   data_bus_read = {31'h0, enable};
         endcase
      end
   end

   // period_div is captured at every bit start so a BAUD write
   // only takes effect from the following bit period.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         tx         <= 1'b1;
         bit_tmr    <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         period_div <= DIV_RESET;
      end else begin
         unique case (state)
            S_IDLE: begin
               tx <= 1'b1;
               if (fifo_pop) begin
                  shift      <= fifo_head;
                  state      <= S_START;
                  tx         <= 1'b0;
                  bit_tmr    <= '0;
                  period_div <= divisor;
               end
            end
            S_START: begin
               if (bit_end) begin
                  state      <= S_DATA;
                  tx         <= shift[0];
                  bit_cnt    <= '0;
                  bit_tmr    <= '0;
                  period_div <= divisor;
               end else begin
                  bit_tmr <= bit_tmr + 1'b1;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  bit_tmr    <= '0;
                  period_div <= divisor;
                  if (bit_cnt == LAST_BIT) begin
                     state <= S_STOP;
                     tx    <= 1'b1;
                  end else begin
                     shift   <= {1'b0, shift[7:1]};
                     tx      <= shift[1];
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  bit_tmr <= bit_tmr + 1'b1;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  bit_tmr    <= '0;
                  period_div <= divisor;
                  if (fifo_pop) begin
                     shift <= fifo_head;
                     state <= S_START;
                     tx    <= 1'b0;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  bit_tmr <= bit_tmr + 1'b1;
               end
            end
         endcase
      end
   end

endmodule
